// File: rtl/poly_piano_keyboard.sv
// Polyphonic PS/2 key-to-note voice allocator; optional VOICE_STEAL_EN reuses a busy voice when all are held.
// Latency: one clk from the key_valid strobe to every output; there is no backpressure, so one event per cycle is accepted.
module poly_piano_keyboard #(
  parameter int VOICES      = 4,
  parameter int OCT_DEFAULT = 4,
  parameter int OCT_MAX     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic                  key_release,
  input  logic [7:0]            keycode,
  output logic [4*VOICES-1:0]   note,
  output logic [4*VOICES-1:0]   octave,
  output logic [VOICES-1:0]     voice_active,
  output logic [3:0]            cur_octave,
  output logic                  key_dropped
);

  localparam int PW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [3:0] OMAX = 4'(OCT_MAX);
  localparam logic [3:0] ODEF = 4'(OCT_DEFAULT);

  logic [VOICES-1:0] active_q, active_d;
  logic [7:0]        code_q [VOICES];
  logic [7:0]        code_d [VOICES];
  logic [3:0]        note_q [VOICES];
  logic [3:0]        note_d [VOICES];
  logic [3:0]        oct_q  [VOICES];
  logic [3:0]        oct_d  [VOICES];
  logic [3:0]        cur_oct_q, cur_oct_d;
  logic              dropped_q, dropped_d;
`ifdef VOICE_STEAL_EN
  logic [PW-1:0]     steal_ptr_q, steal_ptr_d;
`endif

  logic          is_note, upper;
  logic [3:0]    note_val, key_oct;
  logic          hit, free_found;
  logic [PW-1:0] hit_idx, free_idx;

  always_comb begin
    is_note  = 1'b1;
    upper    = 1'b0;
    note_val = 4'd0;
    case (keycode)
      8'h0D: note_val = 4'd1;
      8'h16: note_val = 4'd2;
      8'h15: note_val = 4'd3;
      8'h1E: note_val = 4'd4;
      8'h1D: note_val = 4'd5;
      8'h24: note_val = 4'd6;
      8'h25: note_val = 4'd7;
      8'h2D: note_val = 4'd8;
      8'h2E: note_val = 4'd9;
      8'h2C: note_val = 4'd10;
      8'h36: note_val = 4'd11;
      8'h35: note_val = 4'd12;
      8'h3C: begin note_val = 4'd1;  upper = 1'b1; end
      8'h3E: begin note_val = 4'd2;  upper = 1'b1; end
      8'h43: begin note_val = 4'd3;  upper = 1'b1; end
      8'h46: begin note_val = 4'd4;  upper = 1'b1; end
      8'h44: begin note_val = 4'd5;  upper = 1'b1; end
      8'h4D: begin note_val = 4'd6;  upper = 1'b1; end
      8'h4E: begin note_val = 4'd7;  upper = 1'b1; end
      8'h54: begin note_val = 4'd8;  upper = 1'b1; end
      8'h55: begin note_val = 4'd9;  upper = 1'b1; end
      8'h5B: begin note_val = 4'd10; upper = 1'b1; end
      8'h66: begin note_val = 4'd11; upper = 1'b1; end
      8'h5D: begin note_val = 4'd12; upper = 1'b1; end
      default: is_note = 1'b0;
    endcase
    // Upper row saturates at the top octave rather than wrapping.
    if (!upper)                 key_oct = cur_oct_q;
    else if (cur_oct_q >= OMAX) key_oct = OMAX;
    else                        key_oct = cur_oct_q + 4'd1;
  end

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (active_q[i] && code_q[i] == keycode) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = PW'(i);
      end
    end
  end

  always_comb begin
    active_d  = active_q;
    code_d    = code_q;
    note_d    = note_q;
    oct_d     = oct_q;
    cur_oct_d = cur_oct_q;
    dropped_d = 1'b0;
`ifdef VOICE_STEAL_EN
    steal_ptr_d = steal_ptr_q;
`endif
    if (key_valid) begin
      if (keycode == 8'h5A) begin
        if (!key_release) cur_oct_d = (cur_oct_q >= OMAX) ? 4'd0 : cur_oct_q + 4'd1;
      end else if (keycode == 8'h59) begin
        if (!key_release) cur_oct_d = (cur_oct_q == 4'd0) ? OMAX : cur_oct_q - 4'd1;
      end else if (is_note) begin
        if (key_release) begin
          if (hit) begin
            active_d[hit_idx] = 1'b0;
            note_d[hit_idx]   = 4'd0;
          end
        end else if (!hit) begin
          if (free_found) begin
            active_d[free_idx] = 1'b1;
            code_d[free_idx]   = keycode;
            note_d[free_idx]   = note_val;
            oct_d[free_idx]    = key_oct;
          end else begin
`ifdef VOICE_STEAL_EN
            code_d[steal_ptr_q] = keycode;
            note_d[steal_ptr_q] = note_val;
            oct_d[steal_ptr_q]  = key_oct;
            steal_ptr_d = (steal_ptr_q == PW'(VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
`else
            dropped_d = 1'b1;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= '0;
      cur_oct_q <= ODEF;
      dropped_q <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        code_q[i] <= 8'd0;
        note_q[i] <= 4'd0;
        oct_q[i]  <= ODEF;
      end
`ifdef VOICE_STEAL_EN
      steal_ptr_q <= '0;
`endif
    end else begin
      active_q  <= active_d;
      cur_oct_q <= cur_oct_d;
      dropped_q <= dropped_d;
      code_q    <= code_d;
      note_q    <= note_d;
      oct_q     <= oct_d;
`ifdef VOICE_STEAL_EN
      steal_ptr_q <= steal_ptr_d;
`endif
    end
  end

  always_comb begin
    note   = '0;
    octave = '0;
    for (int i = 0; i < VOICES; i++) begin
      note[4*i +: 4]   = note_q[i];
      octave[4*i +: 4] = oct_q[i];
    end
  end

  assign voice_active = active_q;
  assign cur_octave   = cur_oct_q;
  assign key_dropped  = dropped_q;

endmodule

// File: tb/tb_poly_piano_keyboard.sv
// Directed bench for poly_piano_keyboard (4 voices); expectations follow VOICE_STEAL_EN.
module tb_poly_piano_keyboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic        key_release = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic [15:0] note, octave;
  logic [3:0]  voice_active, cur_octave;
  logic        key_dropped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  poly_piano_keyboard #(.VOICES(4), .OCT_DEFAULT(4), .OCT_MAX(8)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_release(key_release),
    .keycode(keycode), .note(note), .octave(octave), .voice_active(voice_active),
    .cur_octave(cur_octave), .key_dropped(key_dropped)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive on negedge; return on the following negedge with the result registered.
  task automatic ev(input logic rel, input logic [7:0] code);
    @(negedge clk);
    key_valid = 1'b1; key_release = rel; keycode = code;
    @(negedge clk);
    key_valid = 1'b0; key_release = 1'b0; keycode = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_note"},   32'(note),         32'h0000);
    check({tag, "_oct"},    32'(octave),       32'h4444);
    check({tag, "_act"},    32'(voice_active), 32'h0);
    check({tag, "_cur"},    32'(cur_octave),   32'h4);
    check({tag, "_drop"},   32'(key_dropped),  32'h0);
  endtask

  initial begin
    do_reset();
    check_reset("rst");

    // 1: single make
    ev(1'b0, 8'h0D);
    check("t1_note", 32'(note), 32'h0001);
    check("t1_oct",  32'(octave), 32'h4444);
    check("t1_act",  32'(voice_active), 32'h1);

    // 2: three makes, break the middle one
    ev(1'b0, 8'h24);
    check("t2_note_a", 32'(note), 32'h0061);
    ev(1'b0, 8'h5D);
    ev(1'b1, 8'h24);
    check("t2_note", 32'(note), 32'h0C01);
    check("t2_oct",  32'(octave), 32'h4544);
    check("t2_act",  32'(voice_active), 32'h5);
    ev(1'b1, 8'h2E);
    check("t2_orphan_brk", 32'(voice_active), 32'h5);
    ev(1'b0, 8'h77);
    check("t2_unmapped", 32'(note), 32'h0C01);
    @(negedge clk); keycode = 8'h16; key_valid = 1'b0;
    @(negedge clk); keycode = 8'h00;
    check("t2_novalid", 32'(voice_active), 32'h5);

    // 3: typematic repeat
    do_reset();
    ev(1'b0, 8'h0D);
    ev(1'b0, 8'h0D);
    check("t3_act",  32'(voice_active), 32'h1);
    check("t3_note", 32'(note), 32'h0001);

    // 4: octave hotkeys and wrap
    do_reset();
    for (int i = 0; i < 4; i++) ev(1'b0, 8'h5A);
    check("t4_cur8", 32'(cur_octave), 32'h8);
    ev(1'b0, 8'h5A);
    check("t4_wrap0", 32'(cur_octave), 32'h0);
    ev(1'b1, 8'h5A);
    check("t4_brk_ign", 32'(cur_octave), 32'h0);
    ev(1'b0, 8'h59);
    check("t4_wrap8", 32'(cur_octave), 32'h8);
    ev(1'b0, 8'h3C);
    ev(1'b0, 8'h0D);
    check("t4_note", 32'(note), 32'h0011);
    check("t4_oct",  32'(octave), 32'h4488);
    ev(1'b0, 8'h59);
    check("t4_down", 32'(cur_octave), 32'h7);
    check("t4_held", 32'(octave), 32'h4488);

    // 5: all voices busy
    do_reset();
    ev(1'b0, 8'h0D); ev(1'b0, 8'h16); ev(1'b0, 8'h15); ev(1'b0, 8'h1E);
    check("t5_full", 32'(voice_active), 32'hF);
    ev(1'b0, 8'h5A);
    ev(1'b0, 8'h2D);
`ifdef VOICE_STEAL_EN
    check("t5_note",  32'(note), 32'h4328);
    check("t5_oct",   32'(octave), 32'h4445);
    check("t5_drop",  32'(key_dropped), 32'h0);
    ev(1'b0, 8'h2E);
    check("t5_note2", 32'(note), 32'h4398);
    check("t5_act",   32'(voice_active), 32'hF);
`else
    check("t5_note",  32'(note), 32'h4321);
    check("t5_oct",   32'(octave), 32'h4444);
    check("t5_drop",  32'(key_dropped), 32'h1);
    @(negedge clk);
    check("t5_drop0", 32'(key_dropped), 32'h0);
    check("t5_act",   32'(voice_active), 32'hF);
`endif

    // 6: reset mid-operation
    do_reset();
    ev(1'b0, 8'h0D); ev(1'b0, 8'h3E); ev(1'b0, 8'h5A);
    ev(1'b0, 8'h25);
    check("t6_pre", 32'(voice_active), 32'h7);
    do_reset();
    check_reset("t6");
    ev(1'b1, 8'h0D);
    check("t6_brk_act",  32'(voice_active), 32'h0);
    check("t6_brk_note", 32'(note), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
